// File: rtl/keyed_lookup_mux.sv
// keyed_lookup_mux: parameterised key-to-data lookup table with a default value.
// Combinational result (out/hit/multi_hit) for same-cycle decode, plus a
// registered copy (out_q/hit_q/out_valid) for pipelined consumers.
//
// Optional build macro MUXKEY_OR_MERGE_EN:
//   defined   -> multiple matching entries are merged by bitwise OR of their data
//   undefined -> lowest-index matching entry wins (priority encoder)
//
// Table packing, P = KEY_LEN + DATA_LEN:
//   entry i = lut[P*(i+1)-1 : P*i] = {entry_key, entry_data}

module keyed_lookup_mux #(
    parameter int unsigned NR_KEY   = 2,
    parameter int unsigned KEY_LEN  = 7,
    parameter int unsigned DATA_LEN = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    input  logic [KEY_LEN-1:0]                    key,
    input  logic [DATA_LEN-1:0]                   default_out,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]  lut,
    output logic [DATA_LEN-1:0]                   out,
    output logic                                  hit,
    output logic                                  multi_hit,
    output logic [DATA_LEN-1:0]                   out_q,
    output logic                                  hit_q,
    output logic                                  out_valid
);

    localparam int unsigned PAIR_LEN = KEY_LEN + DATA_LEN;

    logic [KEY_LEN-1:0]  entry_key  [NR_KEY];
    logic [DATA_LEN-1:0] entry_data [NR_KEY];
    logic [NR_KEY-1:0]   match;
    logic [DATA_LEN-1:0] sel_data;

    // Unpack the flat table into per-entry key and data fields
    for (genvar i = 0; i < NR_KEY; i++) begin : g_entry
        assign entry_key[i]  = lut[PAIR_LEN*i + DATA_LEN +: KEY_LEN];
        assign entry_data[i] = lut[PAIR_LEN*i +: DATA_LEN];
    end

    // Per-entry exact compare; an unknown compare result falls to "no match"
    always_comb begin
        match = '0;
        for (int unsigned i = 0; i < NR_KEY; i++) begin
            if (entry_key[i] == key) begin
                match[i] = 1'b1;
            end
        end
    end

    // Any-match and two-or-more-match detection without a full popcount
    always_comb begin
        hit       = 1'b0;
        multi_hit = 1'b0;
        for (int unsigned i = 0; i < NR_KEY; i++) begin
            multi_hit = multi_hit | (hit & match[i]);
            hit       = hit | match[i];
        end
    end

`ifdef MUXKEY_OR_MERGE_EN
    // Legacy merge: OR together the data of every matching entry
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NR_KEY; i++) begin
            if (match[i]) begin
                sel_data = sel_data | entry_data[i];
            end
        end
    end
`else
    // Priority select: the lowest-index matching entry wins
    always_comb begin
        logic found;
        sel_data = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < NR_KEY; i++) begin
            if (match[i] && !found) begin
                sel_data = entry_data[i];
                found    = 1'b1;
            end
        end
    end
`endif

    // Fall back to the default value when nothing matches
    assign out = hit ? sel_data : default_out;

    // Registered copy of the lookup, captured only on valid cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q     <= '0;
            hit_q     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_q <= out;
                hit_q <= hit;
            end
        end
    end

endmodule

// File: tb/tb_keyed_lookup_mux.sv
// Bench for keyed_lookup_mux: a 1-entry 7/1 instance and a 3-entry 4/8 instance,
// checked against a table-search model every cycle plus hand-computed literals.

module tb_keyed_lookup_mux;

    logic clk = 1'b0;
    logic rst = 1'b0;

    // Instance A: NR_KEY=1, KEY_LEN=7, DATA_LEN=1
    logic       in_valid_a;
    logic [6:0] key_a;
    logic       def_a;
    logic [7:0] lut_a;
    logic       out_a, hit_a, multi_a, out_q_a, hit_q_a, valid_a;

    // Instance B: NR_KEY=3, KEY_LEN=4, DATA_LEN=8
    logic        in_valid_b;
    logic [3:0]  key_b;
    logic [7:0]  def_b;
    logic [35:0] lut_b;
    logic [7:0]  out_b, out_q_b;
    logic        hit_b, multi_b, hit_q_b, valid_b;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference tables for instance B, index 0 first
    logic [3:0] tk [2][3];
    logic [7:0] td [2][3];
    int         tsel = 0;

    // Model of the registered path
    logic [7:0] mdl_out_q = 8'h00;
    logic       mdl_hit_q = 1'b0;
    logic       mdl_valid = 1'b0;

    keyed_lookup_mux #(.NR_KEY(1), .KEY_LEN(7), .DATA_LEN(1)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .key(key_a),
        .default_out(def_a), .lut(lut_a), .out(out_a), .hit(hit_a),
        .multi_hit(multi_a), .out_q(out_q_a), .hit_q(hit_q_a), .out_valid(valid_a)
    );

    keyed_lookup_mux #(.NR_KEY(3), .KEY_LEN(4), .DATA_LEN(8)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .key(key_b),
        .default_out(def_b), .lut(lut_b), .out(out_b), .hit(hit_b),
        .multi_hit(multi_b), .out_q(out_q_b), .hit_q(hit_q_b), .out_valid(valid_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Search the table: count matches, remember the first, OR all of them
    function automatic void model_b(input int t, input logic [3:0] k, input logic [7:0] d,
                                    output logic [7:0] o, output logic h, output logic m);
        int         n;
        logic [7:0] first;
        logic [7:0] orv;
        n = 0;
        first = 8'h00;
        orv = 8'h00;
        for (int i = 0; i < 3; i++) begin
            if (tk[t][i] == k) begin
                if (n == 0) first = td[t][i];
                orv = orv | td[t][i];
                n++;
            end
        end
        h = (n > 0);
        m = (n >= 2);
`ifdef MUXKEY_OR_MERGE_EN
        o = h ? orv : d;
`else
        o = h ? first : d;
`endif
    endfunction

    function automatic logic [35:0] pack_table(input int t);
        logic [35:0] r;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            r[i*12 +: 12] = {tk[t][i], td[t][i]};
        end
        return r;
    endfunction

    task automatic set_table(input int t);
        tsel  = t;
        lut_b = pack_table(t);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Registered-path model: capture on valid edges out of reset
    always @(posedge clk) begin
        logic [7:0] o;
        logic       h, m;
        if (rst === 1'b1) begin
            model_b(tsel, key_b, def_b, o, h, m);
            mdl_valid <= in_valid_b;
            if (in_valid_b) begin
                mdl_out_q <= o;
                mdl_hit_q <= h;
            end
        end
    end

    // Asynchronous reset clears the modelled registers immediately
    always @(negedge rst) begin
        mdl_out_q <= 8'h00;
        mdl_hit_q <= 1'b0;
        mdl_valid <= 1'b0;
    end

    // Compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        logic [7:0] o;
        logic       h, m;
        if (chk_en) begin
            model_b(tsel, key_b, def_b, o, h, m);
            check("b_out", 32'(out_b), 32'(o));
            check("b_hit", 32'(hit_b), 32'(h));
            check("b_multi_hit", 32'(multi_b), 32'(m));
            check("b_out_q", 32'(out_q_b), 32'(mdl_out_q));
            check("b_hit_q", 32'(hit_q_b), 32'(mdl_hit_q));
            check("b_out_valid", 32'(valid_b), 32'(mdl_valid));
            check("a_out", 32'(out_a), 32'((key_a == 7'h03) ? 1'b1 : def_a));
            check("a_hit", 32'(hit_a), 32'(key_a == 7'h03));
            check("a_multi_hit", 32'(multi_a), 32'(0));
        end
    end

    initial begin
        logic [3:0] key_pool [5];
        tk[0] = '{4'h1, 4'h2, 4'h1};
        td[0] = '{8'hA0, 8'h0B, 8'h05};
        tk[1] = '{4'h7, 4'h7, 4'h7};
        td[1] = '{8'h11, 8'h22, 8'h44};
        key_pool = '{4'h1, 4'h2, 4'h7, 4'hF, 4'h0};

        in_valid_a = 1'b0;
        key_a      = 7'h00;
        def_a      = 1'b0;
        lut_a      = {7'b0000011, 1'b1};
        in_valid_b = 1'b0;
        key_b      = 4'h0;
        def_b      = 8'h00;
        set_table(0);
        rst    = 1'b0;
        chk_en = 1'b1;

        step();
        step();
        check("reset_out_q", 32'(out_q_b), 32'h0);
        check("reset_hit_q", 32'(hit_q_b), 32'h0);
        check("reset_out_valid", 32'(valid_b), 32'h0);
        rst = 1'b1;

        // Single-entry table
        key_a = 7'h03;
        #1;
        check("lit_a_hit_out", 32'(out_a), 32'h1);
        check("lit_a_hit_hit", 32'(hit_a), 32'h1);
        check("lit_a_hit_multi", 32'(multi_a), 32'h0);
        key_a = 7'h33;
        #1;
        check("lit_a_miss_out", 32'(out_a), 32'h0);
        check("lit_a_miss_hit", 32'(hit_a), 32'h0);

        // Duplicate key, unique key, default
        key_b = 4'h1;
        def_b = 8'h00;
        #1;
        check("lit_dup_multi", 32'(multi_b), 32'h1);
`ifdef MUXKEY_OR_MERGE_EN
        check("lit_dup_out", 32'(out_b), 32'hA5);
`else
        check("lit_dup_out", 32'(out_b), 32'hA0);
`endif
        key_b = 4'h2;
        #1;
        check("lit_uniq_out", 32'(out_b), 32'h0B);
        check("lit_uniq_multi", 32'(multi_b), 32'h0);
        key_b = 4'hF;
        def_b = 8'h5C;
        #1;
        check("lit_default_out", 32'(out_b), 32'h5C);
        check("lit_default_hit", 32'(hit_b), 32'h0);

        // Registered path: capture then hold
        step();
        key_b      = 4'h2;
        in_valid_b = 1'b1;
        step();
        check("lit_reg1_out_q", 32'(out_q_b), 32'h0B);
        check("lit_reg1_hit_q", 32'(hit_q_b), 32'h1);
        check("lit_reg1_valid", 32'(valid_b), 32'h1);
        key_b      = 4'hF;
        in_valid_b = 1'b0;
        step();
        check("lit_reg2_out_q", 32'(out_q_b), 32'h0B);
        check("lit_reg2_hit_q", 32'(hit_q_b), 32'h1);
        check("lit_reg2_valid", 32'(valid_b), 32'h0);

        // Reset between edges clears at once; first edge after release is normal
        rst = 1'b0;
        #1;
        check("lit_async_out_q", 32'(out_q_b), 32'h0);
        check("lit_async_hit_q", 32'(hit_q_b), 32'h0);
        check("lit_async_valid", 32'(valid_b), 32'h0);
        #1;
        rst        = 1'b1;
        in_valid_b = 1'b1;
        key_b      = 4'h1;
        def_b      = 8'h00;
        step();
`ifdef MUXKEY_OR_MERGE_EN
        check("lit_post_rst_out_q", 32'(out_q_b), 32'hA5);
`else
        check("lit_post_rst_out_q", 32'(out_q_b), 32'hA0);
`endif
        check("lit_post_rst_valid", 32'(valid_b), 32'h1);

        // Combinational path keeps working while reset is held
        rst        = 1'b0;
        in_valid_b = 1'b1;
        in_valid_a = 1'b1;
        def_b      = 8'h3C;
        for (int t = 0; t < 2; t++) begin
            set_table(t);
            for (int k = 0; k < 16; k++) begin
                key_b = 4'(k);
                key_a = 7'(k);
                step();
                check("sweep_out_q_zero", 32'(out_q_b), 32'h0);
                check("sweep_valid_zero", 32'(valid_b), 32'h0);
                check("sweep_a_out_q_zero", 32'(out_q_a), 32'h0);
            end
        end

        // All-duplicate table pinned by hand
        key_b = 4'h7;
        #1;
`ifdef MUXKEY_OR_MERGE_EN
        check("lit_tri_dup_out", 32'(out_b), 32'h77);
`else
        check("lit_tri_dup_out", 32'(out_b), 32'h11);
`endif
        check("lit_tri_dup_multi", 32'(multi_b), 32'h1);
        rst = 1'b1;

        // Mixed traffic checked by the model
        for (int n = 0; n < 80; n++) begin
            if ((n % 10) == 0) set_table(int'($urandom_range(0, 1)));
            key_b      = key_pool[$urandom_range(0, 4)];
            def_b      = 8'($urandom);
            in_valid_b = 1'($urandom);
            key_a      = ($urandom_range(0, 1) == 0) ? 7'h03 : 7'($urandom);
            def_a      = 1'($urandom);
            step();
        end

        in_valid_b = 1'b0;
        step();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keyed_lookup_mux.md
Name: keyed_lookup_mux

Overview:
- Parameterised key-to-data lookup table with a default value, used for opcode decoding (e.g. "is this a load" from a 7-bit opcode).
- Combinational result is for same-cycle decode.
- A registered copy, with valid and hit flags, is for pipelined consumers in the core.

Parameters:
- NR_KEY, 2, number of key/data pairs in the table (>=1).
- KEY_LEN, 7, width of each key and of the lookup key.
- DATA_LEN, 1, width of each data word and of the output.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- in_valid  input  1  key/lut/default_out are valid this cycle.
- key  input  KEY_LEN  lookup key.
- default_out  input  DATA_LEN  value returned when no entry matches.
- lut  input  NR_KEY*(KEY_LEN+DATA_LEN)  packed table.
- out  output  DATA_LEN  combinational lookup result.
- hit  output  1  combinational: at least one entry matches.
- multi_hit  output  1  combinational: two or more entries match.
- out_q  output  DATA_LEN  registered lookup result.
- hit_q  output  1  registered hit.
- out_valid  output  1  out_q/hit_q updated by the previous edge.

Behaviour:
- Table packing, with P = KEY_LEN+DATA_LEN:
  - entry i occupies lut[P*(i+1)-1 : P*i];
  - entry key = upper KEY_LEN bits of the entry; entry data = lower DATA_LEN bits.
  - Concatenation order {key,data} therefore places the last-listed pair at index 0.
- Match: entry i matches when its key equals key bit-for-bit. No wildcards; X on key treated as mismatch.
- Combinational path:
  - Independent of clk, rst and in_valid.
  - hit = OR of all matches.
  - multi_hit = 1 when the popcount of matches is >=2.
  - out = default_out when hit=0; otherwise per the Optional Feature rule.
  - Zero latency.
- Registered path, all flops async-reset by rst=0:
  - reset: out_q=0, hit_q=0, out_valid=0.
  - rising edge with in_valid=1: out_q<=out, hit_q<=hit.
  - rising edge with in_valid=0: out_q/hit_q hold.
  - every edge: out_valid<=in_valid; latency 1 cycle.
  - Reset asserted mid-operation clears the registers immediately. The combinational path keeps evaluating during reset.
  - First edge after rst deasserts behaves as a normal edge.
- NR_KEY=1: multi_hit is constant 0.
- Duplicate keys in lut are legal; resolution is per the Optional Feature rule.
- Width rules: no truncation or extension. default_out and entry data are both exactly DATA_LEN.

Optional Feature:
- Macro MUXKEY_OR_MERGE_EN.
- Defined: when multiple entries match, out = bitwise OR of all matching entries' data (legacy merge semantics).
- Undefined (default): lowest-index matching entry wins (priority encoder).
- hit, multi_hit and the registered path are identical in both builds.

Test Plan:
- NR_KEY=1, KEY_LEN=7, DATA_LEN=1, lut={7'b0000011,1'b1}, default_out=0:
  - key=7'h03 -> out=1, hit=1, multi_hit=0.
  - key=7'h33 -> out=0, hit=0.
- NR_KEY=3, KEY_LEN=4, DATA_LEN=8, entries idx0={4'h1,8'hA0}, idx1={4'h2,8'h0B}, idx2={4'h1,8'h05}:
  - key=4'h1 -> multi_hit=1; out=8'hA0 (default build) or 8'hA5 (MUXKEY_OR_MERGE_EN).
  - key=4'h2 -> out=8'h0B, multi_hit=0.
- Same config, key=4'hF, default_out=8'h5C -> out=8'h5C, hit=0.
- Registered path, key=4'h2 then 4'hF:
  - in_valid=1 then 0 -> after edge 1 out_q=8'h0B, hit_q=1, out_valid=1.
  - after edge 2 out_q=8'h0B held, out_valid=0.
- Reset:
  - rst=0 asserted between edges with out_q=8'h0B -> out_q=0, hit_q=0, out_valid=0 immediately, not waiting for clk.
  - deassert; in_valid=1, key=4'h1 -> next edge out_q=8'hA0 (default build).
- Combinational independence: hold rst=0, sweep key over all 16 values -> out/hit/multi_hit track the table each value while registered outputs stay 0.
